// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round sequencer.
// Accepts a plaintext block and its expanded key schedule, applies the
// initial AddRoundKey, then drives one external round datapath once per
// clock for rounds 1..NR. The ciphertext is held on a valid/ready output
// until it is consumed.
module aes_round_sequencer #(
    parameter int NR = 10,
    parameter int KW = 128 * (NR + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_data,
    input  logic [KW-1:0] in_w,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic          busy,
    output logic [3:0]    round,
    output logic [127:0]  dp_state,
    output logic [127:0]  dp_key,
    output logic          dp_last,
    input  logic [127:0]  dp_result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_e;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    fsm_e          fsm_q;
    logic [127:0]  state_q;
    logic [KW-1:0] key_q;
    logic [3:0]    round_q;
    logic [127:0]  out_data_q;
    logic          out_valid_q;

    // Next-cycle values derived from current state.
    logic [3:0]    round_d;
    logic [3:0]    key_sel_d;
    logic [127:0]  init_state_d;

    assign round_d      = round_q + 4'd1;
    // Outside ROUND the key mux rests on the round-0 slice.
    assign key_sel_d    = (fsm_q == S_ROUND) ? round_q : 4'd0;
    // Round 0 is the most-significant slice of the incoming schedule.
    assign init_state_d = in_data ^ in_w[KW-1 -: 128];

    assign in_ready  = (fsm_q == S_IDLE);
    assign busy      = (fsm_q != S_IDLE);
    assign round     = round_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign dp_state  = state_q;
    assign dp_last   = (fsm_q == S_ROUND) && (round_q == LAST_ROUND);

    // Select the round key for the active round from the latched schedule.
    always_comb begin
        dp_key = key_q[KW-1 -: 128];
        for (int r = 1; r <= NR; r++) begin
            if (key_sel_d == 4'(r)) begin
                dp_key = key_q[KW-1-128*r -: 128];
            end
        end
    end

    // Control FSM: accept, step rounds through the datapath, hold the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q       <= S_IDLE;
            round_q     <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            state_q     <= '0;
            key_q       <= '0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (in_valid) begin
                        key_q   <= in_w;
                        state_q <= init_state_d;
                        round_q <= 4'd1;
                        fsm_q   <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    state_q <= dp_result;
                    if (round_q == LAST_ROUND) begin
                        out_data_q  <= dp_result;
                        out_valid_q <= 1'b1;
                        fsm_q       <= S_DONE;
                    end else begin
                        round_q <= round_d;
                    end
                end
                S_DONE: begin
                    // Hold the ciphertext until the consumer takes it.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        round_q     <= 4'd0;
                        fsm_q       <= S_IDLE;
                    end
                end
                default: begin
                    fsm_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer. Supplies a behavioural AES round datapath
// on dp_result and compares the sequencer against a full AES-128 model.
module tb_aes_round_sequencer;

    localparam int NR = 10;
    localparam int KW = 128 * (NR + 1);

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_data;
    logic [KW-1:0] in_w;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_data;
    logic          busy;
    logic [3:0]    round;
    logic [127:0]  dp_state;
    logic [127:0]  dp_key;
    logic          dp_last;
    logic [127:0]  dp_result;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_round_sequencer #(.NR(NR)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_w(in_w),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .round(round),
        .dp_state(dp_state), .dp_key(dp_key), .dp_last(dp_last), .dp_result(dp_result)
    );

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00; x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (a^254) then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r, b;
        r = 8'h01; b = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, b);
            b = gmul(b, b);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r+4*c] = b[r+4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    function automatic logic [KW-1:0] key_expand(input logic [127:0] key);
        logic [31:0] w [4*(NR+1)];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [KW-1:0] o;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t[31:24] = t[31:24] ^ rc;
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 4*(NR+1); i++) o[KW-1-32*i -: 32] = w[i];
        return o;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [KW-1:0] w;
        logic [127:0] s;
        w = key_expand(key);
        s = pt ^ w[KW-1 -: 128];
        for (int r = 1; r <= NR; r++) s = aes_round(s, w[KW-1-128*r -: 128], r == NR);
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Behavioural round datapath feeding the sequencer.
    always_comb dp_result = aes_round(dp_state, dp_key, dp_last);

    // ---------------- stimulus helpers ----------------
    // Present a request from a negedge until it is accepted; returns at the
    // negedge following the accept edge.
    task automatic do_accept(input logic [127:0] pt, input logic [KW-1:0] w, output bit ok);
        in_data = pt; in_w = w; in_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_w = '0;
        repeat (3) @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (round !== 4'd0) $display("FAIL reset_round: got %0d want 0", round); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 128'h0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
        n_total++; if (dp_state !== 128'h0 || dp_key !== 128'h0 || dp_last !== 1'b0)
            $display("FAIL reset_dp: got state %h key %h last %b want all 0", dp_state, dp_key, dp_last);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL idle_after_reset: got in_ready %b busy %b want 1 0", in_ready, busy);
        else n_pass++;
    endtask

    task automatic test_fips_sequence();
        logic [KW-1:0] w;
        bit ok;
        w = key_expand(FIPS_KEY);
        out_ready = 1'b1;
        do_accept(FIPS_PT, w, ok);
        n_total++; if (!ok) $display("FAIL fips_accept: got no accept want accept"); else n_pass++;
        for (int j = 0; j < NR; j++) begin
            if (j == 0) begin
                n_total++; if (dp_state !== (FIPS_PT ^ w[KW-1 -: 128]))
                    $display("FAIL first_dp_state: got %h want %h", dp_state, FIPS_PT ^ w[KW-1 -: 128]);
                else n_pass++;
            end
            n_total++; if (round !== 4'(j+1)) $display("FAIL seq_round: got %0d want %0d", round, j+1); else n_pass++;
            n_total++; if (dp_last !== 1'(j == NR-1)) $display("FAIL seq_dp_last r%0d: got %b want %b", j+1, dp_last, (j == NR-1)); else n_pass++;
            n_total++; if (dp_key !== w[KW-1-128*(j+1) -: 128])
                $display("FAIL seq_dp_key r%0d: got %h want %h", j+1, dp_key, w[KW-1-128*(j+1) -: 128]);
            else n_pass++;
            n_total++; if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0)
                $display("FAIL seq_ctrl r%0d: got in_ready %b busy %b out_valid %b want 0 1 0", j+1, in_ready, busy, out_valid);
            else n_pass++;
            @(negedge clk);
        end
        n_total++; if (out_valid !== 1'b1) $display("FAIL fips_latency: got out_valid %b want 1 after %0d edges", out_valid, NR); else n_pass++;
        n_total++; if (out_data !== FIPS_CT) $display("FAIL fips_ct: got %h want %h", out_data, FIPS_CT); else n_pass++;
        n_total++; if (aes_encrypt(FIPS_PT, FIPS_KEY) !== out_data)
            $display("FAIL fips_model: got %h want %h", out_data, aes_encrypt(FIPS_PT, FIPS_KEY));
        else n_pass++;
        @(negedge clk);
        n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || round !== 4'd0)
            $display("FAIL fips_release: got out_valid %b in_ready %b round %0d want 0 1 0", out_valid, in_ready, round);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [127:0] key, pt, exp;
        bit ok;
        key = rand128(); pt = rand128(); exp = aes_encrypt(pt, key);
        out_ready = 1'b0;
        do_accept(pt, key_expand(key), ok);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        n_total++; if (!ok || out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b want 1", out_valid); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_total++; if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0 || busy !== 1'b1)
                $display("FAIL bp_hold c%0d: got v %b data %h rdy %b busy %b want 1 %h 0 1", i, out_valid, out_data, in_ready, busy, exp);
            else n_pass++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1 || round !== 4'd0 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL bp_release: got rdy %b round %0d v %b busy %b want 1 0 0 0", in_ready, round, out_valid, busy);
        else n_pass++;
    endtask

    task automatic test_input_ignore(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] exp;
        bit ok;
        exp = aes_encrypt(pt, key);
        out_ready = 1'b1;
        do_accept(pt, key_expand(key), ok);
        // Scramble every input while the block is in flight.
        in_w = {rand128(), rand128(), rand128(), rand128(), rand128(), rand128(),
                rand128(), rand128(), rand128(), rand128(), rand128()};
        in_data = rand128();
        in_valid = 1'b1;
        repeat (NR - 2) @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        n_total++; if (!ok || out_valid !== 1'b1 || out_data !== exp)
            $display("FAIL ignore_ct: got v %b data %h want 1 %h", out_valid, out_data, exp);
        else n_pass++;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL ignore_no_extra: got busy %b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [127:0] key, pt, exp;
        bit ok, seen;
        key = rand128(); pt = rand128();
        out_ready = 1'b1;
        do_accept(pt, key_expand(key), ok);
        for (int i = 0; i < 10 && round !== 4'd5; i++) @(negedge clk);
        n_total++; if (!ok || round !== 4'd5) $display("FAIL rst_mid_reach: got round %0d want 5", round); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_total++; if (in_ready !== 1'b1 || round !== 4'd0 || out_valid !== 1'b0 || out_data !== 128'h0 || busy !== 1'b0)
            $display("FAIL rst_mid_state: got rdy %b round %0d v %b data %h busy %b want 1 0 0 0 0",
                     in_ready, round, out_valid, out_data, busy);
        else n_pass++;
        seen = 1'b0;
        repeat (15) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_total++; if (seen) $display("FAIL rst_mid_no_output: got out_valid 1 want 0"); else n_pass++;
        key = rand128(); pt = rand128(); exp = aes_encrypt(pt, key);
        do_accept(pt, key_expand(key), ok);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        n_total++; if (!ok || out_valid !== 1'b1 || out_data !== exp)
            $display("FAIL rst_mid_next: got v %b data %h want 1 %h", out_valid, out_data, exp);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [127:0] k [2];
        logic [127:0] p [2];
        logic [127:0] outs [2];
        int acc [2];
        int n_acc, n_out;
        for (int i = 0; i < 2; i++) begin k[i] = rand128(); p[i] = rand128(); end
        n_acc = 0; n_out = 0; acc[0] = 0; acc[1] = 0;
        out_ready = 1'b1;
        in_data = p[0]; in_w = key_expand(k[0]); in_valid = 1'b1;
        for (int i = 0; i < 80 && n_out < 2; i++) begin
            if (out_valid) begin
                outs[n_out] = out_data;
                n_out++;
            end
            if (n_acc == 1) begin
                in_data = p[1]; in_w = key_expand(k[1]);
            end else if (n_acc == 2) begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready && n_acc < 2) begin
                acc[n_acc] = cyc;
                n_acc++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_total++; if (n_out != 2 || n_acc != 2) $display("FAIL b2b_count: got %0d outs %0d accepts want 2 2", n_out, n_acc); else n_pass++;
        n_total++; if (acc[1] - acc[0] != NR + 2) $display("FAIL b2b_spacing: got %0d want %0d", acc[1] - acc[0], NR + 2); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            n_total++; if (n_out != 2 || outs[i] !== aes_encrypt(p[i], k[i]))
                $display("FAIL b2b_ct%0d: got %h want %h", i, outs[i], aes_encrypt(p[i], k[i]));
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_w = '0;
        @(negedge clk);
        test_reset();
        test_fips_sequence();
        test_backpressure();
        test_input_ignore(FIPS_KEY, FIPS_PT);
        test_input_ignore(rand128(), rand128());
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Iterative controller for the AES-128 encryption round datapath. One external round datapath (SubBytes -> ShiftRows -> optional MixColumns -> AddRoundKey) is reused once per clock.
- Accepts a plaintext block plus a full expanded key schedule through a valid/ready handshake.
- Performs the initial AddRoundKey itself, then sequences rounds 1..NR through the datapath.
- Presents the ciphertext through a valid/ready output handshake.
- Replaces free-running, X-detect round stepping with an explicit FSM and round counter.

Parameters:
- NR, 10, number of cipher rounds; key schedule holds NR+1 round keys.
- KW, 128*(NR+1), key schedule width in bits (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  plaintext/key schedule presented.
- in_ready  output  1  block can accept a new request.
- in_data  input  128  plaintext block.
- in_w  input  KW  expanded key schedule. Round r key = in_w[KW-1-128*r -: 128], so round 0 is the top slice and round NR is [127:0].
- out_valid  output  1  ciphertext available.
- out_ready  input  1  consumer accepts ciphertext.
- out_data  output  128  ciphertext.
- busy  output  1  request in flight (ROUND or DONE).
- round  output  4  current round number, 0 when idle.
- dp_state  output  128  state driven into round datapath.
- dp_key  output  128  round key for current round.
- dp_last  output  1  1 = final round, datapath bypasses MixColumns.
- dp_result  input  128  combinational datapath result for dp_state/dp_key/dp_last.

Behaviour:
- FSM states: IDLE, ROUND, DONE.
- Reset (synchronous, any state):
  - FSM -> IDLE; round=0.
  - out_valid=0; out_data=0; busy=0.
  - Internal state register and key register cleared to 0.
  - In-flight request is abandoned; no out_valid is produced for it.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_w into the key register; state_reg <= in_data ^ round-0 key; round <= 1; FSM -> ROUND.
  - in_data/in_w may change after the accept edge.
- ROUND:
  - in_ready=0.
  - Each cycle: dp_state=state_reg; dp_key = key_reg slice for the current round; dp_last=(round==NR).
  - At the edge: state_reg <= dp_result.
  - If round<NR: round <= round+1.
  - If round==NR: out_data <= dp_result; out_valid <= 1; FSM -> DONE.
- DONE:
  - out_valid=1; out_data held stable.
  - While out_ready=0: hold indefinitely (backpressure).
  - On out_ready=1: out_valid <= 0; round <= 0; FSM -> IDLE.
  - in_ready stays 0 during DONE, so a new accept is possible no earlier than the cycle after the output handshake.
- Latency:
  - Accept edge = edge 0; rounds occupy edges 1..NR; out_valid first seen high after edge NR.
  - With out_ready held high: throughput = one block per NR+2 cycles.
- dp_* outputs when not in ROUND: dp_state=state_reg, dp_key=round-0 slice, dp_last=0. The datapath output is ignored.
- busy = (FSM != IDLE).
- in_valid while in_ready=0 is ignored; the requester must hold it.
- The out_data register updates only on the NR-th round edge and on reset.
- No X-propagation checks in RTL; correctness relies on reset.

Test Plan:
- FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f expanded into in_w; in_data=00112233445566778899aabbccddeeff; out_ready=1.
  - Required: out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after the accept edge, high 1 cycle.
- Round sequencing:
  - Same vector; check round steps 1..10 on consecutive cycles.
  - dp_last=1 only in round 10.
  - dp_key equals in_w[1407-128r -:128] each round.
  - First dp_state = in_data ^ in_w[1407:1280].
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid.
  - Required: out_data stable, in_ready=0, busy=1.
  - After out_ready=1 for one cycle: next cycle in_ready=1, round=0.
- Input ignore / key latching:
  - Assert in_valid with different data during ROUND; result unaffected.
  - Change in_w immediately after accept; ciphertext still 69c4e0d8…c55a.
- Reset mid-operation:
  - Assert reset at round 5.
  - Required: next cycle FSM IDLE, in_ready=1, round=0, out_valid=0, out_data=0; no output for the aborted block.
  - A subsequent request completes correctly.
- Back-to-back:
  - Two requests with in_valid held high and out_ready=1.
  - Required: second accepted the cycle after the first output handshake; both ciphertexts correct; spacing 12 cycles between accepts.
